// File: rtl/seq_match_engine.sv
// Memory-sequence game core: plays a growing pattern, checks each press live, handles timeout.
// Optional replay-once-per-round support is compiled in with `define SEQ_REPLAY_EN.
module seq_match_engine #(
    parameter int N_BTN     = 4,
    parameter int DEPTH     = 16,
    parameter int TIMEOUT_S = 10,
    localparam int AW       = $clog2(DEPTH),
    localparam int TW       = $clog2(TIMEOUT_S + 1)
) (
    input  logic             clock_50,
    input  logic             reset,
    input  logic             start,
    input  logic [AW:0]      target_rounds,
    input  logic             step_tick,
    input  logic             sec_tick,
    input  logic [N_BTN-1:0] btn,
`ifdef SEQ_REPLAY_EN
    input  logic             replay,
`endif
    output logic [AW-1:0]    pat_addr,
    input  logic [N_BTN-1:0] pat_data,
    output logic [N_BTN-1:0] leds,
    output logic [AW:0]      round,
    output logic [TW-1:0]    time_left,
    output logic             busy,
    output logic             win,
    output logic             fail,
    output logic             fail_timeout
);

    localparam logic [AW:0]   DEPTH_V = (AW + 1)'(DEPTH);
    localparam logic [TW-1:0] TMO_V   = TW'(TIMEOUT_S);

    typedef enum logic [2:0] {
        S_IDLE, S_GAP, S_ON, S_WAIT, S_OK, S_WIN, S_FAIL
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] i_q, i_d, j_q, j_d;
    logic [AW:0]   round_q, round_d, tgt_q, tgt_d;
    logic [TW-1:0] tl_q, tl_d;
    logic          win_q, win_d, fail_q, fail_d, fto_q, fto_d;
    logic          press, hit;
`ifdef SEQ_REPLAY_EN
    logic          rp_q, rp_d;
`endif

    assign press = (btn != '0);
    // A press only counts as correct when exactly one button matches the ROM entry.
    assign hit   = press && $onehot(btn) && (btn == pat_data);

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        round_d = round_q;
        tgt_d   = tgt_q;
        tl_d    = tl_q;
        win_d   = win_q;
        fail_d  = fail_q;
        fto_d   = fto_q;
`ifdef SEQ_REPLAY_EN
        rp_d    = rp_q;
`endif
        case (state_q)
            S_IDLE, S_WIN, S_FAIL: begin
                if (start) begin
                    state_d = S_GAP;
                    round_d = '0;
                    i_d     = '0;
                    win_d   = 1'b0;
                    fail_d  = 1'b0;
                    fto_d   = 1'b0;
                    tgt_d   = (target_rounds == '0 || target_rounds > DEPTH_V) ? DEPTH_V : target_rounds;
`ifdef SEQ_REPLAY_EN
                    rp_d    = 1'b1;
`endif
                end
            end
            S_GAP: if (step_tick) state_d = S_ON;
            S_ON: begin
                if (step_tick) begin
                    if ({1'b0, i_q} == round_q) begin
                        state_d = S_WAIT;
                        j_d     = '0;
                        tl_d    = TMO_V;
                    end else begin
                        i_d     = i_q + 1'b1;
                        state_d = S_GAP;
                    end
                end
            end
            S_WAIT: begin
                // A press in the same cycle as sec_tick wins; the tick is dropped.
                if (press) begin
                    if (!hit) begin
                        state_d = S_FAIL;
                        fail_d  = 1'b1;
                    end else if ({1'b0, j_q} == round_q) begin
                        state_d = S_OK;
                    end else begin
                        j_d  = j_q + 1'b1;
                        tl_d = TMO_V;
                    end
`ifdef SEQ_REPLAY_EN
                end else if (replay && rp_q && j_q == '0) begin
                    state_d = S_GAP;
                    i_d     = '0;
                    rp_d    = 1'b0;
`endif
                end else if (sec_tick && tl_q != '0) begin
                    tl_d = tl_q - 1'b1;
                    if (tl_q == TW'(1)) begin
                        state_d = S_FAIL;
                        fail_d  = 1'b1;
                        fto_d   = 1'b1;
                    end
                end
            end
            S_OK: begin
                round_d = round_q + 1'b1;
`ifdef SEQ_REPLAY_EN
                rp_d    = 1'b1;
`endif
                if ((round_q + 1'b1) == tgt_q) begin
                    state_d = S_WIN;
                    win_d   = 1'b1;
                end else begin
                    i_d     = '0;
                    state_d = S_GAP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_50) begin
        if (reset) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            round_q <= '0;
            tgt_q   <= '0;
            tl_q    <= '0;
            win_q   <= 1'b0;
            fail_q  <= 1'b0;
            fto_q   <= 1'b0;
`ifdef SEQ_REPLAY_EN
            rp_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            round_q <= round_d;
            tgt_q   <= tgt_d;
            tl_q    <= tl_d;
            win_q   <= win_d;
            fail_q  <= fail_d;
            fto_q   <= fto_d;
`ifdef SEQ_REPLAY_EN
            rp_q    <= rp_d;
`endif
        end
    end

    // ROM is combinational, so address and LEDs follow the registered state directly.
    assign pat_addr     = (state_q == S_WAIT) ? j_q : i_q;
    assign leds         = (state_q == S_ON) ? pat_data : '0;
    assign busy         = (state_q == S_GAP) || (state_q == S_ON) ||
                          (state_q == S_WAIT) || (state_q == S_OK);
    assign round        = round_q;
    assign time_left    = tl_q;
    assign win          = win_q;
    assign fail         = fail_q;
    assign fail_timeout = fto_q;

endmodule

// File: tb/tb_seq_match_engine.sv
// Bench for seq_match_engine: game-rule model checked every cycle plus directed literal checks.
module tb_seq_match_engine;

    localparam int N_BTN = 4, DEPTH = 4, TIMEOUT_S = 5;
    localparam int P_IDLE = 0, P_GAP = 1, P_ON = 2, P_WAIT = 3, P_OK = 4, P_WIN = 5, P_FAIL = 6;

    logic       clk = 1'b0, reset = 1'b0, start = 1'b0, step_tick = 1'b0, sec_tick = 1'b0, rpl = 1'b0;
    logic [2:0] target_rounds = '0;
    logic [3:0] btn = '0;
    logic [1:0] pat_addr;
    logic [3:0] pat_data, leds;
    logic [2:0] round, time_left;
    logic       busy, win, fail, fail_timeout;
    logic [3:0] rom [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    int n_tests = 0, n_fail = 0;
    bit chk_en = 0;

    assign pat_data = rom[pat_addr];

    seq_match_engine #(.N_BTN(N_BTN), .DEPTH(DEPTH), .TIMEOUT_S(TIMEOUT_S)) dut (
        .clock_50(clk), .reset(reset), .start(start), .target_rounds(target_rounds),
        .step_tick(step_tick), .sec_tick(sec_tick), .btn(btn),
`ifdef SEQ_REPLAY_EN
        .replay(rpl),
`endif
        .pat_addr(pat_addr), .pat_data(pat_data), .leds(leds), .round(round),
        .time_left(time_left), .busy(busy), .win(win), .fail(fail), .fail_timeout(fail_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Game-rule model: phase, playback index, answer index, score, timer.
    int m_ph, m_i, m_j, m_round, m_tgt, m_tl;
    bit m_fto, m_rp;

    always @(posedge clk) begin
        if (reset) begin
            m_ph <= P_IDLE; m_i <= 0; m_j <= 0; m_round <= 0; m_tgt <= 0; m_tl <= 0;
            m_fto <= 0; m_rp <= 0;
        end else if (start && (m_ph == P_IDLE || m_ph == P_WIN || m_ph == P_FAIL)) begin
            m_ph <= P_GAP; m_round <= 0; m_i <= 0; m_fto <= 0; m_rp <= 1;
            m_tgt <= (target_rounds == 0 || int'(target_rounds) > DEPTH) ? DEPTH : int'(target_rounds);
        end else begin
            case (m_ph)
                P_GAP: if (step_tick) m_ph <= P_ON;
                P_ON: if (step_tick) begin
                    if (m_i == m_round) begin m_ph <= P_WAIT; m_j <= 0; m_tl <= TIMEOUT_S; end
                    else begin m_i <= m_i + 1; m_ph <= P_GAP; end
                end
                P_WAIT: begin
                    if (btn != 0) begin
                        if (btn != rom[m_j]) m_ph <= P_FAIL;
                        else if (m_j == m_round) m_ph <= P_OK;
                        else begin m_j <= m_j + 1; m_tl <= TIMEOUT_S; end
`ifdef SEQ_REPLAY_EN
                    end else if (rpl && m_rp && m_j == 0) begin
                        m_ph <= P_GAP; m_i <= 0; m_rp <= 0;
`endif
                    end else if (sec_tick) begin
                        m_tl <= m_tl - 1;
                        if (m_tl == 1) begin m_ph <= P_FAIL; m_fto <= 1; end
                    end
                end
                P_OK: begin
                    m_round <= m_round + 1; m_rp <= 1;
                    if (m_round + 1 == m_tgt) m_ph <= P_WIN;
                    else begin m_i <= 0; m_ph <= P_GAP; end
                end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("leds", int'(leds), (m_ph == P_ON) ? int'(rom[m_i]) : 0);
            chk("round", int'(round), m_round);
            chk("time_left", int'(time_left), m_tl);
            chk("busy", int'(busy), int'(m_ph >= P_GAP && m_ph <= P_OK));
            chk("win", int'(win), int'(m_ph == P_WIN));
            chk("fail", int'(fail), int'(m_ph == P_FAIL));
            chk("fail_timeout", int'(fail_timeout), int'(m_fto));
            if (m_ph == P_ON || m_ph == P_WAIT || m_ph == P_IDLE)
                chk("pat_addr", int'(pat_addr), (m_ph == P_WAIT) ? m_j : m_i);
        end
    end

    task automatic cyc(input logic [3:0] b, input logic stp, input logic sec, input logic st);
        btn = b; step_tick = stp; sec_tick = sec; start = st;
        @(posedge clk); #1;
        btn = '0; step_tick = 0; sec_tick = 0; start = 0; rpl = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
    endtask

    task automatic begin_game(input logic [2:0] tgt);
        target_rounds = tgt;
        cyc(4'b0, 0, 0, 1);
    endtask

    task automatic show(input int r);
        for (int k = 0; k <= r; k++) begin
            cyc(4'b0, 1, 0, 0);
            cyc(4'b0, 1, 0, 0);
        end
    endtask

    task automatic answer(input int r);
        for (int k = 0; k <= r; k++) cyc(rom[k], 0, 0, 0);
        cyc(4'b0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk); #1;
        do_reset();
        chk_en = 1;
        chk("rst_round", int'(round), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_leds", int'(leds), 0);
        chk("rst_tl", int'(time_left), 0);

        // Win in two rounds
        begin_game(3'd2);
        cyc(4'b0, 1, 0, 0);
        chk("win_led_r0", int'(leds), 1);
        cyc(4'b0, 1, 0, 0);
        chk("win_tl_load", int'(time_left), 5);
        answer(0);
        chk("win_round1", int'(round), 1);
        cyc(4'b0, 1, 0, 0);
        chk("win_led_r1a", int'(leds), 1);
        cyc(4'b0, 1, 0, 0);
        cyc(4'b0, 1, 0, 0);
        chk("win_led_r1b", int'(leds), 2);
        cyc(4'b0, 1, 0, 0);
        answer(1);
        chk("win_flag", int'(win), 1);
        chk("win_round2", int'(round), 2);
        chk("win_busy", int'(busy), 0);

        // Wrong press in round 0
        begin_game(3'd2);
        show(0);
        cyc(4'b0100, 0, 0, 0);
        chk("wrong_fail", int'(fail), 1);
        chk("wrong_fto", int'(fail_timeout), 0);
        chk("wrong_round", int'(round), 0);

        // Button ignored during playback, then multi-bit press
        begin_game(3'd2);
        cyc(4'b0, 1, 0, 0);
        cyc(4'b0001, 0, 0, 0);
        chk("ign_leds", int'(leds), 1);
        chk("ign_fail", int'(fail), 0);
        cyc(4'b0, 1, 0, 0);
        cyc(4'b0011, 0, 0, 0);
        chk("multi_fail", int'(fail), 1);

        // Timeout
        begin_game(3'd3);
        show(0);
        for (int k = 0; k < 5; k++) begin
            cyc(4'b0, 0, 1, 0);
            chk("to_tl", int'(time_left), 4 - k);
        end
        chk("to_fail", int'(fail), 1);
        chk("to_fto", int'(fail_timeout), 1);

        // Press coinciding with the final tick wins
        begin_game(3'd3);
        show(0);
        answer(0);
        show(1);
        for (int k = 0; k < 4; k++) cyc(4'b0, 0, 1, 0);
        chk("prio_tl1", int'(time_left), 1);
        cyc(4'b0001, 0, 1, 0);
        chk("prio_tl", int'(time_left), 5);
        chk("prio_fail", int'(fail), 0);
        cyc(4'b0010, 0, 0, 0);
        cyc(4'b0, 0, 0, 0);
        chk("prio_round", int'(round), 2);

        // Clamp target 0 to DEPTH
        do_reset();
        begin_game(3'd0);
        for (int r = 0; r < 4; r++) begin
            show(r);
            answer(r);
        end
        chk("clamp_win", int'(win), 1);
        chk("clamp_round", int'(round), 4);

        // Start while busy ignored, then reset during playback
        begin_game(3'd2);
        show(0);
        answer(0);
        target_rounds = 3'd1;
        cyc(4'b0, 0, 0, 1);
        chk("busy_start_round", int'(round), 1);
        chk("busy_start_busy", int'(busy), 1);
        cyc(4'b0, 1, 0, 0);
        chk("pre_rst_leds", int'(leds), 1);
        do_reset();
        chk("mid_rst_leds", int'(leds), 0);
        chk("mid_rst_round", int'(round), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_addr", int'(pat_addr), 0);

`ifdef SEQ_REPLAY_EN
        begin_game(3'd2);
        show(0);
        rpl = 1;
        cyc(4'b0, 0, 1, 0);
        chk("rp_busy", int'(busy), 1);
        chk("rp_leds", int'(leds), 0);
        cyc(4'b0, 1, 0, 0);
        chk("rp_led_again", int'(leds), 1);
        cyc(4'b0, 1, 0, 0);
        rpl = 1;
        cyc(4'b0, 0, 1, 0);
        chk("rp_second_ignored_tl", int'(time_left), 4);
        answer(0);
        chk("rp_round", int'(round), 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
